// File: rtl/freq_word_decoder.sv
// rtl/freq_word_decoder.sv - recovers channel number and error code from a radio frequency register word
// Sequential grid search, one candidate per clock; define FREQ_DEC_ERRCNT_EN to enable the saturating error counter.
module freq_word_decoder #(
  parameter int          NUM_CH  = 32,
  parameter logic [15:0] BASE    = 16'h3C00,
  parameter logic [15:0] STEP    = 16'h0030,
  parameter logic [7:0]  ADDR_LO = 8'h0C,
  parameter logic [7:0]  ADDR_HI = 8'h0D,
  localparam int         CH_W    = $clog2(NUM_CH)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            word_valid_i,
  output logic            word_ready_o,
  input  logic [31:0]     word_data_i,
  output logic            chan_valid_o,
  input  logic            chan_ready_i,
  output logic [CH_W-1:0] chan_num_o,
  output logic [1:0]      chan_err_o,
  output logic [7:0]      err_count_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [1:0]      ERR_OK   = 2'b00;
  localparam logic [1:0]      ERR_ADDR = 2'b01;
  localparam logic [1:0]      ERR_GRID = 2'b10;
  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

  state_t          state_q, state_d;
  logic [15:0]     f_q, f_d;
  logic [15:0]     acc_q, acc_d;
  logic [CH_W-1:0] idx_q, idx_d;
  logic [CH_W-1:0] chan_num_q, chan_num_d;
  logic [1:0]      chan_err_q, chan_err_d;

  logic addr_ok;
  logic hit;
  logic last;

  assign addr_ok = (word_data_i[31:24] == ADDR_LO) && (word_data_i[15:8] == ADDR_HI);
  assign hit     = (acc_q == f_q);
  assign last    = (idx_q == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      f_q        <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      chan_num_q <= '0;
      chan_err_q <= ERR_OK;
    end else begin
      state_q    <= state_d;
      f_q        <= f_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      chan_num_q <= chan_num_d;
      chan_err_q <= chan_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (word_valid_i) begin
          state_d = addr_ok ? S_SEARCH : S_DONE;
        end
      end
      S_SEARCH: begin
        if (hit || last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (chan_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    word_ready_o = 1'b0;
    chan_valid_o = 1'b0;
    case (state_q)
      S_IDLE:  word_ready_o = 1'b1;
      S_DONE:  chan_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Result registers only change on DONE entry, so they hold through the next search.
  always_comb begin
    f_d        = f_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    chan_num_d = chan_num_q;
    chan_err_d = chan_err_q;
    case (state_q)
      S_IDLE: begin
        if (word_valid_i) begin
          f_d = {word_data_i[7:0], word_data_i[23:16]};
          if (!addr_ok) begin
            chan_num_d = '0;
            chan_err_d = ERR_ADDR;
          end else begin
            acc_d = BASE;
            idx_d = '0;
          end
        end
      end
      S_SEARCH: begin
        if (hit) begin
          chan_num_d = idx_q;
          chan_err_d = ERR_OK;
        end else if (last) begin
          chan_num_d = '0;
          chan_err_d = ERR_GRID;
        end else begin
          idx_d = idx_q + CH_W'(1);
          acc_d = acc_q + STEP;
        end
      end
      default: ;
    endcase
  end

  assign chan_num_o = chan_num_q;
  assign chan_err_o = chan_err_q;

`ifdef FREQ_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       err_event;

  assign err_event = (state_q != S_DONE) && (state_d == S_DONE) && (chan_err_d != ERR_OK);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_freq_word_decoder.sv
// tb/tb_freq_word_decoder.sv - self-checking bench for freq_word_decoder
// Table vectors, hand-written handshake/reset sequences and randomized words against an arithmetic model.
module tb_freq_word_decoder;

  localparam int M_NUM_CH = 32;
  localparam int M_BASE   = 'h3C00;
  localparam int M_STEP   = 'h0030;

  logic        clk = 1'b0;
  logic        rst;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic        chan_valid;
  logic        chan_ready;
  logic [4:0]  chan_num;
  logic [1:0]  chan_err;
  logic [7:0]  err_count;

  int checks   = 0;
  int failures = 0;
  int exp_errcnt = 0;

  freq_word_decoder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .word_valid_i (word_valid),
    .word_ready_o (word_ready),
    .word_data_i  (word_data),
    .chan_valid_o (chan_valid),
    .chan_ready_i (chan_ready),
    .chan_num_o   (chan_num),
    .chan_err_o   (chan_err),
    .err_count_o  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    int          num;
    int          err;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Latency counts clock edges from the accept edge (inclusive) until chan_valid is seen.
  function automatic void model(input logic [31:0] w, output int num, output int err, output int lat);
    int f;
    f = {w[7:0], w[23:16]};
    if (w[31:24] != 8'h0C || w[15:8] != 8'h0D) begin
      num = 0; err = 1; lat = 1;
    end else if (f >= M_BASE && (f - M_BASE) % M_STEP == 0 && (f - M_BASE) / M_STEP < M_NUM_CH) begin
      num = (f - M_BASE) / M_STEP; err = 0; lat = num + 2;
    end else begin
      num = 0; err = 2; lat = M_NUM_CH + 1;
    end
  endfunction

  function automatic int errcnt_next(input int cur, input int err);
`ifdef FREQ_DEC_ERRCNT_EN
    if (err != 0 && cur < 255) return cur + 1;
    return cur;
`else
    if (err > 3) return cur + 1;
    return 0;
`endif
  endfunction

  task automatic run_check(input string tag, input logic [31:0] w, input int e_num, input int e_err,
                           input int e_lat, input bit rdy_early);
    int lat;
    @(negedge clk);
    chk({tag, "_ready_before"}, word_ready, 1);
    word_valid = 1'b1;
    word_data  = w;
    chan_ready = rdy_early;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    word_valid = 1'b0;
    word_data  = $urandom;
    while (!chan_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_num"}, chan_num, e_num);
    chk({tag, "_err"}, chan_err, e_err);
    exp_errcnt = errcnt_next(exp_errcnt, e_err);
    chk({tag, "_errcnt"}, err_count, exp_errcnt);
    chan_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chan_ready = 1'b0;
    chk({tag, "_valid_after"}, chan_valid, 0);
  endtask

  initial begin
    int m_num, m_err, m_lat;
    logic [31:0] w;
    logic [15:0] f;

    vecs[0] = '{32'h0c000d3c, 0,  0, 2};
    vecs[1] = '{32'h0cD00d41, 31, 0, 33};
    vecs[2] = '{32'h0c200d3d, 6,  0, 8};
    vecs[3] = '{32'h0b000d3c, 0,  1, 1};
    vecs[4] = '{32'h0c100d3c, 0,  2, 33};
    vecs[5] = '{32'h0c000d00, 0,  2, 33};
    vecs[6] = '{32'h0c000d42, 0,  2, 33};
    vecs[7] = '{32'h0c000e3c, 0,  1, 1};

    rst = 1'b1;
    word_valid = 1'b0;
    word_data  = '0;
    chan_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", word_ready, 1);
    chk("rst_valid", chan_valid, 0);
    chk("rst_num", chan_num, 0);
    chk("rst_err", chan_err, 0);
    chk("rst_errcnt", err_count, 0);

    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].word, vecs[i].num, vecs[i].err, vecs[i].lat, i[0]);
    end

    // Consumer stalls: result and busy status must hold, offered words ignored.
    run_check("prep", 32'h0b000d3c, 0, 1, 1, 1'b1);
    @(negedge clk);
    word_valid = 1'b1;
    word_data  = 32'h0c200d3d;
    @(posedge clk);
    @(negedge clk);
    word_data = 32'h0c000d3c;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (chan_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", chan_valid, 1);
      chk("hold_num", chan_num, 6);
      chk("hold_ready", word_ready, 0);
      @(posedge clk);
      @(negedge clk);
    end
    word_valid = 1'b0;
    exp_errcnt = errcnt_next(exp_errcnt, 0);
    chan_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chan_ready = 1'b0;
    chk("release_ready", word_ready, 1);
    chk("release_valid", chan_valid, 0);
    run_check("after_hold", 32'h0c000d3c, 0, 0, 2, 1'b0);

    // Reset at edge E10 mid-search aborts the decode.
    @(negedge clk);
    word_valid = 1'b1;
    word_data  = 32'h0cD00d41;
    @(posedge clk);
    @(negedge clk);
    word_valid = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_valid", chan_valid, 0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_errcnt = 0;
    chk("abort_ready", word_ready, 1);
    chk("abort_valid", chan_valid, 0);
    chk("abort_num", chan_num, 0);
    chk("abort_err", chan_err, 0);
    chk("abort_errcnt", err_count, 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("abort_quiet", chan_valid, 0);
    end

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          f = 16'(M_BASE + $urandom_range(0, M_NUM_CH - 1) * M_STEP);
          w = {8'h0C, f[7:0], 8'h0D, f[15:8]};
        end
        1: begin
          f = 16'($urandom_range(0, 'hFFFF));
          w = {8'h0C, f[7:0], 8'h0D, f[15:8]};
        end
        2: begin
          w = $urandom;
          if (w[31:24] == 8'h0C) w[31:24] = 8'h0B;
        end
        default: w = $urandom;
      endcase
      model(w, m_num, m_err, m_lat);
      run_check($sformatf("rnd%0d", i), w, m_num, m_err, m_lat, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 300; i++) begin
      run_check("errcnt_sat", 32'h0b000d3c, 0, 1, 1, 1'b1);
    end
`ifdef FREQ_DEC_ERRCNT_EN
    chk("errcnt_final", err_count, 'hFF);
`else
    chk("errcnt_final", err_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
